particle_ctl: RTL and testbench

PARTICLE_CTL -- requirements
Module: particle_ctl

---
 rtl/variable_pkg.sv | 38 +++
 rtl/frame_tick_gen.sv | 25 ++
 rtl/particle_ctl.sv | 168 ++++++++++++++++
 tb/tb_particle_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
// Shared geometry constants, FSM state type and fixed-point helpers for the particle path.
package variable_pkg;

    localparam int PARTICLE_WIDTH  = 8;
    localparam int PARTICLE_HEIGHT = 8;
    localparam int GROUND_Y        = 600;
    localparam int SCREEN_W        = 800;
    localparam int TARGET_W        = 32;
    localparam int TARGET_H        = 32;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StFly,
        StHit
    } particle_state_e;

    // Saturate a 15-bit signed sum into the 14-bit signed position range.
    function automatic logic signed [13:0] sat14(input logic signed [14:0] v);
        if (v > 15'sd8191) begin
            return {1'b0, {13{1'b1}}};
        end else if (v < -15'sd8192) begin
            return {1'b1, 13'd0};
        end
        return v[13:0];
    endfunction

    // Clamp a signed position onto the 12-bit unsigned pixel range.
    function automatic logic [11:0] clamp12(input logic signed [13:0] v);
        if (v < 14'sd0) begin
            return 12'd0;
        end else if (v > 14'sd4095) begin
            return 12'hfff;
        end
        return v[11:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the vblnk rising edge into a registered one-cycle frame tick.
module frame_tick_gen (
    input  logic clk60MHz,
    input  logic rst_n,
    input  logic vblnk,
    output logic frame_tick
);

    logic r_vblnk;
    logic r_tick;

    // Delay vblnk by one cycle and register the 0-to-1 transition.
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_vblnk <= vblnk;
            r_tick  <= vblnk & ~r_vblnk;
        end
    end

    assign frame_tick = r_tick;

endmodule

// File: rtl/particle_ctl.sv
// Thrown-particle controller: ballistic update per frame, target collision and ground/edge miss.
module particle_ctl
    import variable_pkg::*;
#(
    parameter int GRAVITY         = 1,
    parameter int HIT_HOLD_FRAMES = 8
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        launch_valid,
    output logic        launch_ready,
    input  logic [11:0] launch_x,
    input  logic [11:0] launch_y,
    input  logic [7:0]  launch_vx,
    input  logic [7:0]  launch_vy,
    input  logic [11:0] target_x,
    input  logic [11:0] target_y,
    output logic [11:0] xpos_particle,
    output logic [11:0] ypos_particle,
    output logic        particle_active,
    output logic        hit,
    output logic        miss
);

    localparam int HOLD_W = $clog2(HIT_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HIT_HOLD_FRAMES - 1);

    localparam logic signed [15:0] PW = 16'(PARTICLE_WIDTH);
    localparam logic signed [15:0] PH = 16'(PARTICLE_HEIGHT);
    localparam logic signed [15:0] TW = 16'(TARGET_W);
    localparam logic signed [15:0] TH = 16'(TARGET_H);
    localparam logic signed [15:0] GY = 16'(GROUND_Y);
    localparam logic signed [15:0] SW = 16'(SCREEN_W);

    particle_state_e r_state, w_state_d;

    // Positions are kept unclamped so a particle above the screen top keeps its true arc.
    logic signed [13:0] r_x, r_y, w_x_d, w_y_d;
    logic signed [7:0]  r_vx, r_vy, w_vx_d, w_vy_d;
    logic [HOLD_W-1:0]  r_hold, w_hold_d;
    logic               r_hit, r_miss, w_hit_d, w_miss_d;

    logic               w_tick;
    logic signed [13:0] w_nx, w_ny;
    logic signed [8:0]  w_vy_sum;
    logic signed [7:0]  w_vy_n;
    logic signed [15:0] w_nx16, w_ny16, w_tx16, w_ty16;
    logic               w_collide, w_out;

    frame_tick_gen u_frame_tick_gen (
        .clk60MHz  (clk60MHz),
        .rst_n     (rst_n),
        .vblnk     (vblnk),
        .frame_tick(w_tick)
    );

    // Candidate next position and velocity for the upcoming FLY tick.
    always_comb begin
        w_nx     = sat14({r_x[13], r_x} + {{7{r_vx[7]}}, r_vx});
        w_ny     = sat14({r_y[13], r_y} + {{7{r_vy[7]}}, r_vy});
        w_vy_sum = {r_vy[7], r_vy} + 9'(GRAVITY);
        if (w_vy_sum > 9'sd127) begin
            w_vy_n = 8'sd127;
        end else if (w_vy_sum < -9'sd128) begin
            w_vy_n = 8'h80;
        end else begin
            w_vy_n = w_vy_sum[7:0];
        end
    end

    // Box overlap and out-of-field tests at the new position.
    always_comb begin
        w_nx16    = {{2{w_nx[13]}}, w_nx};
        w_ny16    = {{2{w_ny[13]}}, w_ny};
        w_tx16    = {4'b0000, target_x};
        w_ty16    = {4'b0000, target_y};
        w_collide = (w_nx16 < w_tx16 + TW) && (w_tx16 < w_nx16 + PW) &&
                    (w_ny16 < w_ty16 + TH) && (w_ty16 < w_ny16 + PH);
        w_out     = (w_ny16 >= GY) || (w_nx16 < 16'sd0) || (w_nx16 >= SW);
    end

    // Next-state and datapath decisions; registers hold by default.
    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_vx_d    = r_vx;
        w_vy_d    = r_vy;
        w_hold_d  = r_hold;
        w_hit_d   = 1'b0;
        w_miss_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (launch_valid) begin
                    w_state_d = StArmed;
                    w_x_d     = {2'b00, launch_x};
                    w_y_d     = {2'b00, launch_y};
                    w_vx_d    = launch_vx;
                    w_vy_d    = launch_vy;
                end
            end
            StArmed: begin
                if (w_tick) begin
                    w_state_d = StFly;
                end
            end
            StFly: begin
                if (w_tick) begin
                    w_x_d  = w_nx;
                    w_y_d  = w_ny;
                    w_vy_d = w_vy_n;
                    // Collision outranks a miss landing on the same frame.
                    if (w_collide) begin
                        w_hit_d   = 1'b1;
                        w_hold_d  = '0;
                        w_state_d = StHit;
                    end else if (w_out) begin
                        w_miss_d  = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StHit: begin
                if (w_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_hold_d  = '0;
                        w_state_d = StIdle;
                    end else begin
                        w_hold_d = r_hold + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, datapath and outcome pulse registers.
    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_x     <= '0;
            r_y     <= '0;
            r_vx    <= '0;
            r_vy    <= '0;
            r_hold  <= '0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_x     <= w_x_d;
            r_y     <= w_y_d;
            r_vx    <= w_vx_d;
            r_vy    <= w_vy_d;
            r_hold  <= w_hold_d;
            r_hit   <= w_hit_d;
            r_miss  <= w_miss_d;
        end
    end

    assign launch_ready    = (r_state == StIdle);
    assign particle_active = (r_state != StIdle);
    assign xpos_particle   = clamp12(r_x);
    assign ypos_particle   = clamp12(r_y);
    assign hit             = r_hit;
    assign miss            = r_miss;

endmodule

// File: tb/tb_particle_ctl.sv
// Directed bench for particle_ctl: a GRAVITY=0 and a GRAVITY=1 instance share all inputs.
module tb_particle_ctl;

    logic        clk60MHz;
    logic        rst_n;
    logic        vblnk;
    logic        launch_valid;
    logic [11:0] launch_x, launch_y, target_x, target_y;
    logic [7:0]  launch_vx, launch_vy;

    logic        rdy0, act0, hit0, miss0;
    logic        rdy1, act1, hit1, miss1;
    logic [11:0] x0, y0, x1, y1;

    int n_checks = 0;
    int n_fail   = 0;
    int hit_cnt1 = 0;
    int miss_cnt1 = 0;

    logic f_hit0, f_miss0, f_hit1, f_miss1;

    particle_ctl #(.GRAVITY(0), .HIT_HOLD_FRAMES(8)) u_dut0 (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .vblnk(vblnk),
        .launch_valid(launch_valid), .launch_ready(rdy0),
        .launch_x(launch_x), .launch_y(launch_y),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .target_x(target_x), .target_y(target_y),
        .xpos_particle(x0), .ypos_particle(y0),
        .particle_active(act0), .hit(hit0), .miss(miss0)
    );

    particle_ctl #(.GRAVITY(1), .HIT_HOLD_FRAMES(8)) u_dut1 (
        .clk60MHz(clk60MHz), .rst_n(rst_n), .vblnk(vblnk),
        .launch_valid(launch_valid), .launch_ready(rdy1),
        .launch_x(launch_x), .launch_y(launch_y),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .target_x(target_x), .target_y(target_y),
        .xpos_particle(x1), .ypos_particle(y1),
        .particle_active(act1), .hit(hit1), .miss(miss1)
    );

    initial clk60MHz = 1'b0;
    always #8 clk60MHz = ~clk60MHz;

    // Count high cycles of the outcome pulses; a stretched pulse shows up as an extra count.
    always @(negedge clk60MHz) begin
        if (!rst_n) begin
            hit_cnt1  = 0;
            miss_cnt1 = 0;
        end else begin
            if (hit1) hit_cnt1++;
            if (miss1) miss_cnt1++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One vblnk pulse; snapshots pulses in the cycle after the frame tick.
    task automatic do_frame();
        vblnk = 1'b1;
        @(negedge clk60MHz);
        @(negedge clk60MHz);
        f_hit0  = hit0;
        f_miss0 = miss0;
        f_hit1  = hit1;
        f_miss1 = miss1;
        repeat (3) @(negedge clk60MHz);
        vblnk = 1'b0;
        repeat (4) @(negedge clk60MHz);
    endtask

    task automatic do_launch(input logic [11:0] lx, input logic [11:0] ly,
                             input logic [7:0] vx, input logic [7:0] vy, input bit hold);
        launch_valid = 1'b1;
        launch_x     = lx;
        launch_y     = ly;
        launch_vx    = vx;
        launch_vy    = vy;
        @(negedge clk60MHz);
        if (!hold) launch_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        launch_valid = 1'b0;
        @(negedge clk60MHz);
        rst_n = 1'b1;
        @(negedge clk60MHz);
    endtask

    initial begin
        int ey, evy;
        rst_n = 1'b0;
        vblnk = 1'b0;
        launch_valid = 1'b0;
        launch_x = '0; launch_y = '0; launch_vx = '0; launch_vy = '0;
        target_x = 12'd4000; target_y = 12'd4000;
        f_hit0 = 0; f_miss0 = 0; f_hit1 = 0; f_miss1 = 0;
        #5;
        check_eq("rst_x", x1, 0);
        check_eq("rst_y", y1, 0);
        check_eq("rst_active", act1, 0);
        check_eq("rst_hit_miss", {hit1, miss1}, 0);
        repeat (2) @(negedge clk60MHz);
        rst_n = 1'b1;
        @(negedge clk60MHz);
        check_eq("rst_ready", rdy1, 1);

        // Straight flight on the zero-gravity instance.
        do_launch(12'd100, 12'd200, 8'd4, 8'd0, 1'b0);
        check_eq("sf_armed_active", act0, 1);
        check_eq("sf_armed_ready", rdy0, 0);
        check_eq("sf_armed_x", x0, 100);
        do_frame();
        check_eq("sf_arm_tick_x", x0, 100);
        do_frame();
        check_eq("sf_x1", x0, 104);
        do_frame();
        check_eq("sf_x2", x0, 108);
        do_frame();
        check_eq("sf_x3", x0, 112);
        check_eq("sf_y", y0, 200);
        repeat (5) @(negedge clk60MHz);
        check_eq("sf_stable_x", x0, 112);
        check_eq("sf_no_miss", f_miss0, 0);

        // Parabola to the ground on the gravity instance.
        do_reset();
        do_launch(12'd0, 12'd500, 8'd2, 8'hfc, 1'b0);
        do_frame();
        ey = 500;
        evy = -4;
        for (int t = 1; t <= 20; t++) begin
            ey += evy;
            evy += 1;
            do_frame();
            check_eq($sformatf("pb_y%0d", t), y1, ey);
            check_eq($sformatf("pb_x%0d", t), x1, 2 * t);
            check_eq($sformatf("pb_miss%0d", t), f_miss1, (t == 20) ? 1 : 0);
        end
        check_eq("pb_ground_y", y1, 610);
        check_eq("pb_miss_count", miss_cnt1, 1);
        check_eq("pb_hit_count", hit_cnt1, 0);
        check_eq("pb_ready", rdy1, 1);
        check_eq("pb_inactive", act1, 0);

        // Hit and hold.
        do_reset();
        target_x = 12'd120;
        target_y = 12'd200;
        do_launch(12'd100, 12'd200, 8'd4, 8'd0, 1'b0);
        do_frame();
        do_frame();
        do_frame();
        do_frame();
        check_eq("hh_no_early_hit", f_hit1, 0);
        do_frame();
        check_eq("hh_hit", f_hit1, 1);
        check_eq("hh_x", x1, 116);
        check_eq("hh_y", y1, 206);
        for (int i = 1; i <= 7; i++) do_frame();
        check_eq("hh_active_7", act1, 1);
        check_eq("hh_frozen_x", x1, 116);
        check_eq("hh_frozen_y", y1, 206);
        do_frame();
        check_eq("hh_active_8", act1, 0);
        check_eq("hh_ready_8", rdy1, 1);
        check_eq("hh_hit_count", hit_cnt1, 1);

        // Collision and ground on the same tick.
        do_reset();
        target_x = 12'd46;
        target_y = 12'd590;
        do_launch(12'd0, 12'd500, 8'd2, 8'hfc, 1'b0);
        do_frame();
        for (int t = 1; t <= 19; t++) do_frame();
        check_eq("sim_no_hit_19", f_hit1, 0);
        do_frame();
        check_eq("sim_hit", f_hit1, 1);
        check_eq("sim_miss", f_miss1, 0);
        do_frame();
        check_eq("sim_hit_count", hit_cnt1, 1);
        check_eq("sim_miss_count", miss_cnt1, 0);
        check_eq("sim_active", act1, 1);

        // Clamping and left-edge miss on the zero-gravity instance.
        do_reset();
        target_x = 12'd4000;
        target_y = 12'd4000;
        do_launch(12'd10, 12'd5, 8'd1, 8'hf6, 1'b0);
        do_frame();
        do_frame();
        check_eq("cl_y_clamp", y0, 0);
        check_eq("cl_x", x0, 11);
        check_eq("cl_no_miss", f_miss0, 0);
        check_eq("cl_active", act0, 1);
        do_reset();
        do_launch(12'd3, 12'd100, 8'hfc, 8'd0, 1'b0);
        do_frame();
        do_frame();
        check_eq("lm_miss", f_miss0, 1);
        check_eq("lm_x_clamp", x0, 0);

        // Held launch_valid must not relaunch; reset mid-flight aborts silently.
        do_reset();
        do_launch(12'd100, 12'd200, 8'd4, 8'd0, 1'b1);
        launch_x = 12'd300;
        do_frame();
        do_frame();
        check_eq("hs_no_relaunch_x", x1, 104);
        check_eq("hs_ready", rdy1, 0);
        do_frame();
        check_eq("hs_fly_x", x1, 108);
        launch_valid = 1'b0;
        vblnk = 1'b1;
        @(negedge clk60MHz);
        rst_n = 1'b0;
        #1;
        check_eq("hs_async_x", x1, 0);
        check_eq("hs_async_y", y1, 0);
        check_eq("hs_async_active", act1, 0);
        check_eq("hs_async_pulses", {hit1, miss1}, 0);
        vblnk = 1'b0;
        @(negedge clk60MHz);
        rst_n = 1'b1;
        @(negedge clk60MHz);
        check_eq("hs_ready_after", rdy1, 1);
        repeat (4) @(negedge clk60MHz);
        check_eq("hs_no_pulse", hit_cnt1 + miss_cnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
